cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_alu.sv | 29 ++
 rtl/cpu_core.sv | 160 ++++++++++++++++
 tb/tb_cpu_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, FSM state encoding, instruction field
// positions and immediate sign-extension helpers for the cpu_core slice.
package cpu_pkg;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LUI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field positions
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RD_MSB   = 11;
    localparam int unsigned RD_LSB   = 9;
    localparam int unsigned RS_MSB   = 8;
    localparam int unsigned RS_LSB   = 6;
    localparam int unsigned IMM6_MSB = 5;
    localparam int unsigned IMM9_MSB = 8;

    // Control FSM states; encodings fixed to match the legacy design
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMRD  = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational two-operand unit for ADD..MUL.
// The multiplier exists only when CPU_MUL_EN is defined; otherwise opcode 6
// passes operand a through unchanged, so the destination keeps its value.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] result_o
);

    // Select the arithmetic/logic result for the current opcode
    always_comb begin
        result_o = a_i;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
`ifdef CPU_MUL_EN
            OP_MUL:  result_o = a_i * b_i;
`endif
            default: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: 16-bit multi-cycle CPU (IDLE/FETCH/DECODE/EXEC/MEMRD/HALT)
// talking to a synchronous, word-addressed BRAM.
// Optional feature: define CPU_MUL_EN to implement opcode 6 as MUL.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] address,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        wren_n,
    output logic        oen_n
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] regs_q [8];

    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [3:0]  op;
    logic [2:0]  rd_idx, rs_idx;
    logic [15:0] imm6_s, imm9_s;
    logic [15:0] rd_val, rs_val;
    logic [15:0] ea, alu_res, pc_inc, br_target;

    assign op        = ir_q[OP_MSB:OP_LSB];
    assign rd_idx    = ir_q[RD_MSB:RD_LSB];
    assign rs_idx    = ir_q[RS_MSB:RS_LSB];
    assign imm6_s    = sext6(ir_q[IMM6_MSB:0]);
    assign imm9_s    = sext9(ir_q[IMM9_MSB:0]);
    assign rd_val    = regs_q[rd_idx];
    assign rs_val    = regs_q[rs_idx];
    assign ea        = rs_val + imm6_s;
    assign pc_inc    = pc_q + 16'd1;
    assign br_target = pc_inc + imm9_s;

    cpu_alu u_alu (
        .op_i     (op),
        .a_i      (rd_val),
        .b_i      (rs_val),
        .result_o (alu_res)
    );

    // Next-state, PC, IR and register-file write control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_we    = 1'b0;
        rf_waddr = rd_idx;
        rf_wdata = '0;
        unique case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = data_in;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_res;
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm9_s;
                    end
                    OP_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = {ir_q[7:0], rd_val[7:0]};
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = rd_val + imm9_s;
                    end
                    OP_LD: begin
                        pc_d    = pc_q;
                        state_d = ST_MEMRD;
                    end
                    OP_JMP:  pc_d = ea;
                    OP_BZ:   pc_d = (rd_val == '0) ? br_target : pc_inc;
                    OP_BNZ:  pc_d = (rd_val != '0) ? br_target : pc_inc;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            ST_MEMRD: begin
                rf_we    = 1'b1;
                rf_wdata = data_in;
                pc_d     = pc_inc;
                state_d  = ST_FETCH;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state, PC and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Register file r0-r7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Memory bus outputs; outside memory cycles the address shows pc
    // (except IDLE, which drives 0) with both strobes released
    always_comb begin
        address  = pc_q;
        data_out = '0;
        oen_n    = 1'b1;
        wren_n   = 1'b1;
        unique case (state_q)
            ST_IDLE:  address = '0;
            ST_FETCH: oen_n   = 1'b0;
            ST_EXEC: begin
                if (op == OP_LD) begin
                    address = ea;
                    oen_n   = 1'b0;
                end else if (op == OP_ST) begin
                    address  = ea;
                    data_out = rd_val;
                    wren_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed program bench for cpu_core with a BRAM model.
// Honours CPU_MUL_EN for the expected MUL result.
module tb_cpu_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        wren_n;
    logic        oen_n;

    int checks   = 0;
    int failures = 0;

`ifdef CPU_MUL_EN
    localparam logic [15:0] MUL_EXP = 16'h5F90;
`else
    localparam logic [15:0] MUL_EXP = 16'h012C;
`endif

    cpu_core #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in),
        .wren_n   (wren_n),
        .oen_n    (oen_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous BRAM, 256 words, plus a back-door load port for programs
    logic [15:0] mem [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    always @(posedge clk) begin
        if (!wren_n)
            mem[address[7:0]] <= data_out;
        else if (load_en)
            mem[load_addr] <= load_data;
        if (!oen_n)
            data_in <= mem[address[7:0]];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic chk_reset_bus(input string tag);
        chk({tag, "_addr"}, address, 16'h0000);
        chk({tag, "_dout"}, data_out, 16'h0000);
        chk({tag, "_strb"}, {14'd0, oen_n, wren_n}, 16'h0003);
    endtask

    task automatic t_fetch(input logic [15:0] pc);
        @(negedge clk);
        chk("fetch_addr", address, pc);
        chk("fetch_strb", {14'd0, oen_n, wren_n}, 16'h0001);
    endtask

    task automatic quiet_cycle(input string tag);
        @(negedge clk);
        chk(tag, {14'd0, oen_n, wren_n}, 16'h0003);
    endtask

    task automatic t_alu(input logic [15:0] pc);
        t_fetch(pc);
        quiet_cycle("decode_strb");
        quiet_cycle("exec_strb");
    endtask

    task automatic t_ld(input logic [15:0] pc, input logic [15:0] a);
        t_fetch(pc);
        quiet_cycle("ld_decode_strb");
        @(negedge clk);
        chk("ld_exec_addr", address, a);
        chk("ld_exec_strb", {14'd0, oen_n, wren_n}, 16'h0001);
        quiet_cycle("ld_memrd_strb");
    endtask

    task automatic t_st_nowait(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] d);
        t_fetch(pc);
        quiet_cycle("st_decode_strb");
        @(negedge clk);
        chk("st_addr", address, a);
        chk("st_data", data_out, d);
        chk("st_strb", {14'd0, oen_n, wren_n}, 16'h0002);
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Program 1
        load_word(8'h00, 16'h7205); // LDI  r1,5
        load_word(8'h01, 16'hE3F9); // ADDI r1,-7
        load_word(8'h02, 16'h7E40); // LDI  r7,0x40
        load_word(8'h03, 16'hB1C0); // JMP  r7+0
        load_word(8'h40, 16'hA214); // ST   r1,[r0+20]
        load_word(8'h41, 16'h7410); // LDI  r2,16
        load_word(8'h42, 16'h7634); // LDI  r3,0x34
        load_word(8'h43, 16'h8612); // LUI  r3,0x12
        load_word(8'h44, 16'hA681); // ST   r3,[r2+1]
        load_word(8'h45, 16'h9881); // LD   r4,[r2+1]
        load_word(8'h46, 16'hA815); // ST   r4,[r0+21]
        load_word(8'h47, 16'h7BFF); // LDI  r5,-1
        load_word(8'h48, 16'hEA01); // ADDI r5,1
        load_word(8'h49, 16'hCBFE); // BZ   r5,-2
        load_word(8'h4A, 16'hDA01); // BNZ  r5,+1
        load_word(8'h4B, 16'hF000); // HALT (skipped)
        load_word(8'h4C, 16'h7C00); // LDI  r6,0
        load_word(8'h4D, 16'hDC05); // BNZ  r6,+5 (falls through)
        load_word(8'h4E, 16'h722C); // LDI  r1,0x2C
        load_word(8'h4F, 16'h8201); // LUI  r1,0x01 -> 300
        load_word(8'h50, 16'h742C); // LDI  r2,0x2C
        load_word(8'h51, 16'h8401); // LUI  r2,0x01 -> 300
        load_word(8'h52, 16'h6280); // MUL  r1,r2
        load_word(8'h53, 16'hA216); // ST   r1,[r0+22]
        load_word(8'h54, 16'h5880); // XOR  r4,r2
        load_word(8'h55, 16'hA817); // ST   r4,[r0+23]
        load_word(8'h56, 16'h2680); // SUB  r3,r2
        load_word(8'h57, 16'hA618); // ST   r3,[r0+24]
        load_word(8'h58, 16'h3500); // AND  r2,r4
        load_word(8'h59, 16'hA419); // ST   r2,[r0+25]
        load_word(8'h5A, 16'h4AC0); // OR   r5,r3
        load_word(8'h5B, 16'hAA1A); // ST   r5,[r0+26]
        load_word(8'h5C, 16'hF000); // HALT

        @(negedge clk);
        chk_reset_bus("in_reset");
        rst_n = 1'b1;
        #1 chk_reset_bus("idle");

        t_alu(16'h0000);
        t_alu(16'h0001);
        t_alu(16'h0002);
        t_alu(16'h0003);
        t_st_nowait(16'h0040, 16'd20, 16'hFFFE);
        t_alu(16'h0041);
        t_alu(16'h0042);
        t_alu(16'h0043);
        t_st_nowait(16'h0044, 16'd17, 16'h1234);
        t_ld(16'h0045, 16'd17);
        t_st_nowait(16'h0046, 16'd21, 16'h1234);
        t_alu(16'h0047);
        t_alu(16'h0048);
        t_alu(16'h0049);
        t_alu(16'h0048);
        t_alu(16'h0049);
        t_alu(16'h004A);
        t_alu(16'h004C);
        t_alu(16'h004D);
        t_alu(16'h004E);
        t_alu(16'h004F);
        t_alu(16'h0050);
        t_alu(16'h0051);
        t_alu(16'h0052);
        t_st_nowait(16'h0053, 16'd22, MUL_EXP);
        t_alu(16'h0054);
        t_st_nowait(16'h0055, 16'd23, 16'h1318);
        t_alu(16'h0056);
        t_st_nowait(16'h0057, 16'd24, 16'h1108);
        t_alu(16'h0058);
        t_st_nowait(16'h0059, 16'd25, 16'h0108);
        t_alu(16'h005A);
        t_st_nowait(16'h005B, 16'd26, 16'h1109);
        t_alu(16'h005C);

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("halt_hold", {oen_n, wren_n, address[13:0]}, {2'b11, 14'h005C});
        end

        // Reset pulse while halted restarts at RESET_PC
        rst_n = 1'b0;
        #1 chk_reset_bus("halt_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_reset_bus("halt_idle");
        t_alu(16'h0000);
        t_fetch(16'h0001);

        // Program 2: register clear, mid-store reset, PC wrap
        rst_n = 1'b0;
        load_word(8'h00, 16'hA21F); // ST   r1,[r0+31]
        load_word(8'h01, 16'h7DFF); // LDI  r6,-1
        load_word(8'h02, 16'hAC1E); // ST   r6,[r0+30]
        load_word(8'h03, 16'hB180); // JMP  r6+0 -> 0xFFFF
        load_word(8'hFF, 16'h0000); // NOP
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_reset_bus("p2_idle");
        t_st_nowait(16'h0000, 16'd31, 16'h0000);
        t_alu(16'h0001);
        t_st_nowait(16'h0002, 16'd30, 16'hFFFF);
        rst_n = 1'b0;
        #1 chk_reset_bus("mid_store_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_reset_bus("p2_idle2");
        t_st_nowait(16'h0000, 16'd31, 16'h0000);
        t_alu(16'h0001);
        t_st_nowait(16'h0002, 16'd30, 16'hFFFF);
        t_alu(16'h0003);
        t_alu(16'hFFFF);
        t_fetch(16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
